// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - default widths and payload layout for the decode->execute stage
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_ALU_W  = 10;
    localparam int PIPE_SELA_W = 6;
    localparam int PIPE_SELB_W = 5;
    localparam int PIPE_SELO_W = 6;
    localparam int PIPE_CNT_W  = 16;

    typedef struct packed {
        logic [PIPE_ALU_W-1:0]  aluCtrl;
        logic [PIPE_DATA_W-1:0] imm;
        logic                   imm_en;
        logic [PIPE_SELA_W-1:0] selA;
        logic [PIPE_SELB_W-1:0] selB;
        logic [PIPE_SELO_W-1:0] selOut;
    } dec_ex_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - generic valid/ready payload register with flush
module pipe_skid_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Flush only drops valid; data keeps its last loaded value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/dec_ex_pipe_stage.sv
// rtl/dec_ex_pipe_stage.sv - decode->execute pipeline register with handshake, flush, stall counter
// Optional SKID_BUF_EN adds a skid entry so in_ready comes straight from a flop.
module dec_ex_pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DATA_W,
    parameter int ALU_W  = PIPE_ALU_W,
    parameter int SELA_W = PIPE_SELA_W,
    parameter int SELB_W = PIPE_SELB_W,
    parameter int SELO_W = PIPE_SELO_W,
    parameter int CNT_W  = PIPE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ALU_W-1:0]  in_aluCtrl,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_imm_en,
    input  logic [SELA_W-1:0] in_selA,
    input  logic [SELB_W-1:0] in_selB,
    input  logic [SELO_W-1:0] in_selOut,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ALU_W-1:0]  out_aluCtrl,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_imm_en,
    output logic [SELA_W-1:0] out_selA,
    output logic [SELB_W-1:0] out_selB,
    output logic [SELO_W-1:0] out_selOut,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int PAY_W = ALU_W + DATA_W + 1 + SELA_W + SELB_W + SELO_W;

    logic [PAY_W-1:0] in_data;
    logic [PAY_W-1:0] main_in_data;
    logic [PAY_W-1:0] main_data;
    logic             main_in_valid;
    logic             main_in_ready;

    assign in_data = {in_aluCtrl, in_imm, in_imm_en, in_selA, in_selB, in_selOut};
    assign {out_aluCtrl, out_imm, out_imm_en, out_selA, out_selB, out_selOut} = main_data;

`ifdef SKID_BUF_EN
    logic             in_ready_q;
    logic             in_xfer;
    logic             skid_valid;
    logic             skid_ready;
    logic             skid_in_valid;
    logic             skid_valid_next;
    logic [PAY_W-1:0] skid_data;

    // A held skid entry always drains into main before new input.
    assign in_xfer       = in_valid && in_ready_q;
    assign main_in_valid = skid_valid || in_xfer;
    assign main_in_data  = skid_valid ? skid_data : in_data;
    assign skid_in_valid = in_xfer && !main_in_ready;

    pipe_skid_reg #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_ready),
        .in_data   (in_data),
        .out_valid (skid_valid),
        .out_ready (main_in_ready),
        .out_data  (skid_data)
    );

    always_comb begin
        skid_valid_next = skid_valid;
        if (flush)
            skid_valid_next = 1'b0;
        else if (skid_in_valid && skid_ready)
            skid_valid_next = 1'b1;
        else if (main_in_ready)
            skid_valid_next = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            in_ready_q <= 1'b1;
        else
            in_ready_q <= !skid_valid_next;
    end

    assign in_ready = in_ready_q;
`else
    assign main_in_valid = in_valid;
    assign main_in_data  = in_data;
    assign in_ready      = main_in_ready;
`endif

    pipe_skid_reg #(.W(PAY_W)) u_main (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (main_in_valid),
        .in_ready  (main_in_ready),
        .in_data   (main_in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (main_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_dec_ex_pipe_stage.sv
// tb/tb_dec_ex_pipe_stage.sv - scoreboard bench for dec_ex_pipe_stage (default and SKID_BUF_EN builds)
module tb_dec_ex_pipe_stage;
    import pipe_pkg::*;

    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [9:0]      in_aluCtrl;
    logic [31:0]     in_imm;
    logic            in_imm_en;
    logic [5:0]      in_selA;
    logic [4:0]      in_selB;
    logic [5:0]      in_selOut;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [9:0]      out_aluCtrl;
    logic [31:0]     out_imm;
    logic            out_imm_en;
    logic [5:0]      out_selA;
    logic [4:0]      out_selB;
    logic [5:0]      out_selOut;
    logic [CW-1:0]   stall_cnt;

    int n_cmp = 0;
    int n_err = 0;
    dec_ex_t exp_q[$];

    dec_ex_pipe_stage #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluCtrl(in_aluCtrl), .in_imm(in_imm), .in_imm_en(in_imm_en),
        .in_selA(in_selA), .in_selB(in_selB), .in_selOut(in_selOut),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluCtrl(out_aluCtrl), .out_imm(out_imm), .out_imm_en(out_imm_en),
        .out_selA(out_selA), .out_selB(out_selB), .out_selOut(out_selOut),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic dec_ex_t mk(input logic [31:0] imm);
        dec_ex_t p;
        p.aluCtrl = imm[9:0] ^ 10'h2A5;
        p.imm     = imm;
        p.imm_en  = imm[0];
        p.selA    = imm[5:0] + 6'd1;
        p.selB    = imm[4:0] ^ 5'h1F;
        p.selOut  = imm[5:0] ^ 6'h15;
        return p;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] imm);
        dec_ex_t p;
        p = mk(imm);
        in_valid   = v;
        in_aluCtrl = p.aluCtrl;
        in_imm     = p.imm;
        in_imm_en  = p.imm_en;
        in_selA    = p.selA;
        in_selB    = p.selB;
        in_selOut  = p.selOut;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected-item producer: every accepted input is queued; flush or reset squashes everything held.
    always @(negedge clk) begin
        if (rst || flush)
            exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back(mk(in_imm));
    end

    always @(negedge clk) begin
        dec_ex_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {32'd0, out_imm}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("out_payload",
                      {4'd0, out_aluCtrl, out_imm, out_imm_en, out_selA, out_selB, out_selOut},
                      {4'd0, e});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_payload", {4'd0, out_aluCtrl, out_imm, out_imm_en, out_selA, out_selB, out_selOut}, 64'd0);
        check("reset_stall_cnt", {60'd0, stall_cnt}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Async reset while holding a valid, stalled entry
        drive(1'b1, 32'h77);
        tick();
        drive(1'b0, 32'd0);
        check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_imm", {32'd0, out_imm}, 64'd0);
        check("async_rst_cnt", {60'd0, stall_cnt}, 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Streaming 1..8 with 1-cycle latency
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i));
            tick();
            check("stream_valid", {63'd0, out_valid}, 64'd1);
            check("stream_imm", {32'd0, out_imm}, 64'(i));
        end
        drive(1'b0, 32'd0);
        tick();
        check("bubble_valid", {63'd0, out_valid}, 64'd0);

        // Stall for 5 cycles
        out_ready = 1'b0;
        drive(1'b1, 32'h100);
        tick();
        drive(1'b0, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_imm", {32'd0, out_imm}, 64'h100);
`ifdef SKID_BUF_EN
            check("stall_in_ready", {63'd0, in_ready}, 64'd1);
`else
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
`endif
        end
        check("stall_cnt_5", {60'd0, stall_cnt}, 64'd5);
        out_ready = 1'b1;
        tick();
        check("stall_release_valid", {63'd0, out_valid}, 64'd0);

        // Flush with a simultaneous input that must be dropped
        out_ready = 1'b0;
        drive(1'b1, 32'h200);
        tick();
        drive(1'b1, 32'hDEAD);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0);
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_cnt", {60'd0, stall_cnt}, 64'd6);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("flush_no_dead", {63'd0, out_imm == 32'hDEAD}, 64'd0);
            check("flush_hold_imm", {32'd0, out_imm}, 64'h200);
            check("flush_valid_stays", {63'd0, out_valid}, 64'd0);
        end

        // A,B,C with out_ready low for one cycle
        begin
            logic [31:0] items[3];
            int idx;
            logic acc;
            items[0] = 32'hA; items[1] = 32'hB; items[2] = 32'hC;
            idx = 0;
            for (int c = 0; c < 8; c++) begin
                out_ready = (c != 1);
                if (idx < 3) drive(1'b1, items[idx]);
                else         drive(1'b0, 32'd0);
                @(negedge clk);
                acc = in_valid && in_ready;
`ifdef SKID_BUF_EN
                if (c == 1) check("skid_in_ready_c1", {63'd0, in_ready}, 64'd1);
                if (c == 2) check("skid_in_ready_c2", {63'd0, in_ready}, 64'd0);
                if (c == 3) check("skid_in_ready_c3", {63'd0, in_ready}, 64'd1);
`else
                if (c == 1) check("noskid_in_ready_c1", {63'd0, in_ready}, 64'd0);
`endif
                tick();
                if (acc) idx++;
            end
            check("abc_all_sent", 64'(idx), 64'd3);
            check("abc_drained", 64'(exp_q.size()), 64'd0);
            check("abc_cnt", {60'd0, stall_cnt}, 64'd7);
        end

        // Saturation of the 4-bit stall counter
        out_ready = 1'b0;
        drive(1'b1, 32'h300);
        tick();
        drive(1'b0, 32'd0);
        repeat (20) tick();
        check("sat_cnt", {60'd0, stall_cnt}, 64'd15);
        repeat (3) tick();
        check("sat_cnt_hold", {60'd0, stall_cnt}, 64'd15);
        check("sat_imm_hold", {32'd0, out_imm}, 64'h300);

        out_ready = 1'b1;
        tick(); tick();
        check("final_drained", 64'(exp_q.size()), 64'd0);
        check("final_valid", {63'd0, out_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
